// File: rtl/unpack_pkg.sv
// unpack_pkg: shared types and constants for the serial depacketizer.
// State encoding, default preamble and payload-size derivation.
package unpack_pkg;

  typedef enum logic {
    SEARCH  = 1'b0,
    PAYLOAD = 1'b1
  } state_e;

  localparam logic [31:0] PREAMBLE_DEF = 32'hEB90_1F3C;

  function automatic int payload_bytes(
    input int bits_pack,
    input int bits_pre,
    input int bits_word
  );
    return (bits_pack - bits_pre) / bits_word;
  endfunction

endpackage

// File: rtl/preamble_detector.sv
// preamble_detector: serial shift register with preamble comparator.
// UNPACK_ERR_TOL_EN selects Hamming-distance matching over exact match.
module preamble_detector
  import unpack_pkg::*;
#(
  parameter int                       SIZE_PREAMBLE    = 32,
  parameter logic [SIZE_PREAMBLE-1:0] PREAMBLE         = PREAMBLE_DEF,
  parameter int                       PREAMBLE_MAX_ERR = 2
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_shift,
  input  logic i_clear,
  input  logic i_data,
  output logic o_match
);

  logic [SIZE_PREAMBLE-1:0] sr_q, sr_d;
  logic [SIZE_PREAMBLE-1:0] cand;

  // A cleared register must never look like the preamble.
  if (PREAMBLE == '0) begin : g_zero_pre
    $error("PREAMBLE must be nonzero");
  end
  if (PREAMBLE_MAX_ERR < 0 || PREAMBLE_MAX_ERR >= SIZE_PREAMBLE) begin : g_bad_err
    $error("PREAMBLE_MAX_ERR out of range");
  end

  // Candidate window includes the bit offered this cycle.
  assign cand = {sr_q[SIZE_PREAMBLE-2:0], i_data};

  // Next shift-register value: clear wins over shift.
  always_comb begin
    sr_d = sr_q;
    if (i_clear) begin
      sr_d = '0;
    end else if (i_shift) begin
      sr_d = cand;
    end
  end

  // Shift register state.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

`ifdef UNPACK_ERR_TOL_EN
  localparam int ERRW = $clog2(SIZE_PREAMBLE + 1);
  logic [SIZE_PREAMBLE-1:0] diff;
  logic [ERRW-1:0]          err;

  // Popcount of mismatching bits against the tolerance.
  always_comb begin
    diff = cand ^ PREAMBLE;
    err  = '0;
    for (int k = 0; k < SIZE_PREAMBLE; k++) begin
      err = err + ERRW'(diff[k]);
    end
    o_match = (err <= ERRW'(PREAMBLE_MAX_ERR));
  end
`else
  assign o_match = (cand == PREAMBLE);
`endif

endmodule

// File: rtl/unpack.sv
// unpack: serial-to-byte depacketizer, locks on a 32-bit preamble.
// Optional UNPACK_ERR_TOL_EN enables error-tolerant preamble matching.
module unpack
  import unpack_pkg::*;
#(
  parameter int          SIZE_BIT_PACK    = 1976,
  parameter int          SIZE_PREAMBLE    = 32,
  parameter logic [31:0] PREAMBLE         = PREAMBLE_DEF,
  parameter int          SIZE_OUTPUT_BIT  = 8,
  parameter int          PREAMBLE_MAX_ERR = 2
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic                       i_data,
  input  logic                       i_valid,
  output logic                       o_ready,
  output logic [SIZE_OUTPUT_BIT-1:0] o_data,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic                       o_last,
  output logic                       o_lock
);

  localparam int PB  = payload_bytes(SIZE_BIT_PACK, SIZE_PREAMBLE,
                                     SIZE_OUTPUT_BIT);
  localparam int BCW = $clog2(SIZE_OUTPUT_BIT);
  localparam int W   = SIZE_OUTPUT_BIT;

  state_e             state_q, state_d;
  logic [BCW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]         byte_cnt_q, byte_cnt_d;
  logic [W-1:0]       shreg_q, shreg_d;
  logic [W-1:0]       data_q, data_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic               accept;
  logic               match;
  logic               sr_shift;
  logic               sr_clear;

  assign o_ready = !valid_q || i_ready;
  assign accept  = i_valid && o_ready;

  preamble_detector #(
    .SIZE_PREAMBLE    (SIZE_PREAMBLE),
    .PREAMBLE         (PREAMBLE[SIZE_PREAMBLE-1:0]),
    .PREAMBLE_MAX_ERR (PREAMBLE_MAX_ERR)
  ) u_det (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_shift   (sr_shift),
    .i_clear   (sr_clear),
    .i_data    (i_data),
    .o_match   (match)
  );

  // Next state: preamble search, byte assembly and output handshake.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shreg_d    = shreg_q;
    data_d     = data_q;
    valid_d    = valid_q;
    last_d     = last_q;
    sr_shift   = 1'b0;
    sr_clear   = 1'b0;
    if (valid_q && i_ready) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
    unique case (state_q)
      SEARCH: begin
        if (accept) begin
          sr_shift = 1'b1;
          if (match) begin
            state_d    = PAYLOAD;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
          end
        end
      end
      PAYLOAD: begin
        if (accept) begin
          shreg_d   = {shreg_q[W-2:0], i_data};
          bit_cnt_d = bit_cnt_q + BCW'(1);
          if (bit_cnt_q == BCW'(W - 1)) begin
            data_d  = {shreg_q[W-2:0], i_data};
            valid_d = 1'b1;
            last_d  = (byte_cnt_q == 8'(PB - 1));
            if (byte_cnt_q == 8'(PB - 1)) begin
              state_d    = SEARCH;
              sr_clear   = 1'b1;
              byte_cnt_d = '0;
            end else begin
              byte_cnt_d = byte_cnt_q + 8'd1;
            end
          end
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= SEARCH;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      shreg_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shreg_q    <= shreg_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_last  = last_q;
  assign o_lock  = (state_q == PAYLOAD);

endmodule

// File: doc/unpack.md
# unpack

Serial-to-byte depacketizer and the receive-side counterpart of the packet builder. Consumes a 1-bit stream of fixed-size packets, locks on a fixed 32-bit preamble, strips it, and emits the payload as bytes with a valid/ready handshake and an end-of-packet flag. Sits between the bit-level demodulator/sampler and the byte-oriented payload sink.

## Interface
- SIZE_BIT_PACK, 1976: total packet length in bits, preamble included
- SIZE_PREAMBLE, 32: preamble length in bits
- PREAMBLE, 32'hEB90_1F3C: preamble pattern; first received bit is the MSB
- SIZE_OUTPUT_BIT, 8: output word width
- PREAMBLE_MAX_ERR, 2: maximum tolerated preamble bit mismatches (used only with UNPACK_ERR_TOL_EN)
- PAYLOAD_BYTES, (SIZE_BIT_PACK-SIZE_PREAMBLE)/SIZE_OUTPUT_BIT: derived, 243

- i_clk  in  1  clock; all logic on the rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_data  in  1  serial input bit
- i_valid  in  1  i_data is valid this cycle
- o_ready  out  1  a bit is accepted when i_valid && o_ready
- o_data  out  8  payload byte; the first received bit is the MSB
- o_valid  out  1  o_data is valid
- i_ready  in  1  sink accepts the byte when o_valid && i_ready
- o_last  out  1  qualifies o_data as the final payload byte of the packet
- o_lock  out  1  high while in PAYLOAD state

## Operation
- States:
  - SEARCH: every accepted bit shifts into a 32-bit register, left shift, new bit into the LSB. On a match → PAYLOAD, with bit_cnt=0 and byte_cnt=0.
  - PAYLOAD: accepted bits shift into an 8-bit byte register. On the 8th bit, the byte loads into o_data with o_valid=1; o_last=1 when byte_cnt==PAYLOAD_BYTES-1. On the last byte → SEARCH, preamble shift register cleared to 0.
- Match condition is exact equality with PREAMBLE. The shift register compare includes the bit being accepted in that cycle.
- Bits outside a packet are discarded. PREAMBLE must be nonzero, so a cleared register cannot false-match.
- o_ready = !o_valid || i_ready, combinational. A byte completing while the previous byte is accepted in the same cycle replaces it without a bubble.
- bit_cnt is 3 bits and wraps 7→0. byte_cnt is 8 bits, range 0..PAYLOAD_BYTES-1, and clears on packet end.
- Reset values: o_data=0, o_valid=0, o_last=0, o_lock=0, state=SEARCH, all counters and shift registers 0. o_ready is 1 out of reset.
- Reset asserted mid-packet: the partial packet is dropped and no o_last is issued. After release, the block searches afresh.

## Timing
- Preamble: the 32nd preamble bit accepted in cycle N gives o_lock=1 in cycle N+1.
- Byte latency: the 8th bit of a byte accepted in cycle N gives o_valid=1 with that byte in cycle N+1.
- o_data and o_last stay stable while o_valid && !i_ready.
- o_lock drops in the cycle after the last payload bit is accepted. The next packet's preamble bits are accepted from that same cycle onward, so back-to-back packets need no gap.
- Throughput: one bit per cycle. Backpressure reaches the bit input only when a completed byte is still unaccepted.

## Configuration
- UNPACK_ERR_TOL_EN defined: a match is declared when the Hamming distance between the shift register and PREAMBLE is ≤ PREAMBLE_MAX_ERR (popcount of XOR), still combinational in the accepting cycle.
- UNPACK_ERR_TOL_EN undefined: exact match only, and PREAMBLE_MAX_ERR is ignored.

## Structure
- Package unpack_pkg holds:
  - the state enum (SEARCH, PAYLOAD)
  - the default PREAMBLE constant
  - the PAYLOAD_BYTES derivation as a function of packet/preamble sizes
- Sub-module preamble_detector holds the shift register, the clear input, and the match output. It contains the UNPACK_ERR_TOL_EN popcount logic.

## Test plan
- Ideal packet: 5 noise bits, then PREAMBLE, then payload bytes 0x00..0xF2 (243), i_ready=1 → 243 bytes in order; o_last only on 0xF2; o_lock falls after it.
- Bit slip: 13 random prefix bits containing a partial preamble, then a valid packet → lock exactly at the true preamble; payload bytes correct.
- Backpressure: i_ready low for 20 cycles while byte 0x05 is held → o_data stays 0x05; o_ready=0 until accepted; no bits lost.
- Back-to-back: two packets with no gap → 486 bytes, two o_last pulses.
- Reset mid-packet: i_reset_n low after byte 100, then a fresh packet → no o_last from the first packet; second packet complete.
- Error tolerance: preamble with 2 flipped bits → locks with UNPACK_ERR_TOL_EN, stays in SEARCH without it; 3 flipped bits → never locks.
